alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the execute interface: holds a small program, fetches and decodes each
//  instruction, reads operands from a 4x8 register file and issues opcode/A/B to the ALU execute
//  unit over a valid/ready handshake. Captures result and carry back into the register file.
//  Sits between the host (program load, start) and the execute unit (control unit + ALU).
// PARAMETERS
//  PROG_DEPTH  16  program words; power of two, >=2
//  DW          8   operand/result width; fixed at 8 by the instruction format
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  prog_we      in   1      program write strobe; ignored while busy=1
//  prog_addr    in   log2(PROG_DEPTH)  program write address
//  prog_wdata   in   19     instruction word
//  start        in   1      begin execution at pc=0; ignored while busy=1
//  busy         out  1      1 from the cycle after accepted start until halt
//  halted       out  1      1 after a HALT instruction; cleared by start or reset
//  pc           out  log2(PROG_DEPTH)  address of current instruction
//  alu_opcode   out  3      opcode to execute unit (000 add..111 compare)
//  alu_a        out  8      operand A
//  alu_b        out  8      operand B
//  alu_valid    out  1      issue request
//  alu_ready    in   1      execute unit accepts issue
//  res_valid    in   1      one-cycle pulse: alu_result/alu_carry valid
//  alu_result   in   8      result
//  alu_carry    in   1      carry / borrow / divide-by-zero flag
//  carry_flag   out  1      last captured alu_carry
//  dbg_sel      in   2      register-file debug read select
//  dbg_data     out  8      combinational read of reg[dbg_sel]
// BEHAVIOUR
//  Instr format: [18]=halt [17:15]=op [14:13]=rd [12:11]=ra [10:9]=rb [8]=use_imm [7:0]=imm.
//  B operand = use_imm ? imm : reg[rb]; A = reg[ra].
//  Reset: state IDLE, pc=0, busy=0, halted=0, alu_valid=0, alu_opcode/a/b=0, carry_flag=0,
//   all regs=0. Program memory is NOT reset. Reset mid-operation abandons the instruction, no wb.
//  FSM: IDLE -start-> FETCH (sync memory read, 1 cycle) -> DECODE (regs read; halt=1 -> HALTED,
//   no issue) -> ISSUE (alu_valid=1; opcode/A/B stable until alu_ready=1 sampled at edge)
//   -> WAIT (alu_valid=0; stay until res_valid=1) -> WB (reg[rd]<=alu_result,
//   carry_flag<=alu_carry, pc<=pc+1) -> FETCH.
//  HALTED: busy=0, halted=1, pc holds HALT address; start -> pc=0, FETCH.
//  Min throughput: 5 cycles/instr when alu_ready=1 in ISSUE and res_valid in first WAIT cycle.
//  pc wraps PROG_DEPTH-1 -> 0 (no implicit halt).
//  res_valid outside WAIT ignored; alu_ready outside ISSUE ignored.
//  prog_we and start in same cycle while idle: write takes effect; execution sees new word.
//  Writeback and regs: reg write occurs only in WB; rd==ra in next instr sees new value.
//  dbg_data reflects writes from the cycle after WB edge.
// STRUCTURE
//  Shared package: opcode constants (ADD..CMP), instruction field bit positions, FSM state enc.
//  One sub-module: seq_regfile (4x8, 2 comb read ports + debug port, 1 sync write port, sync clear).
//  Program memory inferred inline as sync-read array.
// TESTING
//  Load {ADD r1=r0+imm5; ADD r2=r1+imm7; HALT}, start -> r1=5, r2=12, halted=1, pc=2, busy=0.
//  r1=200, ADD r3=r1+imm100 -> r3=44, carry_flag=1; next SUB r0=r0-r0 -> carry_flag=0.
//  Hold alu_ready=0 for 6 cycles in ISSUE -> alu_valid/opcode/A/B stable throughout, one issue.
//  DIV imm0 with model setting carry -> reg[rd]=0, carry_flag=1; stray res_valid in FETCH ignored.
//  Assert reset during WAIT -> next cycle IDLE, alu_valid=0, regs 0, program retained; restart works.
//  PROG_DEPTH=4 program with no HALT -> pc sequence 0,1,2,3,0; start while busy ignored.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared types for the ALU sequencer: ALU opcodes, instruction field layout and FSM state encoding.
package alu_sequencer_pkg;

  localparam int DW = 8;   // operand/result width, fixed by the 8-bit immediate
  localparam int IW = 19;  // instruction word width

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_DIV = 3'd6,
    OP_CMP = 3'd7
  } alu_op_e;

  // Field order gives [18]=halt [17:15]=op [14:13]=rd [12:11]=ra [10:9]=rb [8]=use_imm [7:0]=imm.
  typedef struct packed {
    logic          halt;
    alu_op_e       op;
    logic [1:0]    rd;
    logic [1:0]    ra;
    logic [1:0]    rb;
    logic          use_imm;
    logic [DW-1:0] imm;
  } instr_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } seq_state_e;

  function automatic logic is_busy_state(seq_state_e s);
    return (s != S_IDLE) && (s != S_HALTED);
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Issue/result channel between the sequencer (master) and the execute unit (slave).
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
();
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_valid;
  logic          alu_ready;
  logic          res_valid;
  logic [DW-1:0] alu_result;
  logic          alu_carry;

  modport master (
    output alu_opcode, alu_a, alu_b, alu_valid,
    input  alu_ready, res_valid, alu_result, alu_carry
  );

  modport slave (
    input  alu_opcode, alu_a, alu_b, alu_valid,
    output alu_ready, res_valid, alu_result, alu_carry
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// 4x8 register file: two combinational operand ports, one debug port, one synchronous write port.
module seq_regfile
  import alu_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [1:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [1:0]    ra_sel,
  input  logic [1:0]    rb_sel,
  input  logic [1:0]    dbg_sel,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic [DW-1:0] dbg_data
);

  logic [3:0][DW-1:0] regs_q;
  logic [3:0][DW-1:0] regs_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  // NOTE: state updates use <= so all flops sample pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign ra_data  = regs_q[ra_sel];
  assign rb_data  = regs_q[rb_sel];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: fetches instructions from a small program memory, reads operands from the
// register file, issues them to the execute unit and writes the returned result back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter  int PROG_DEPTH = 16,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [IW-1:0]        prog_wdata,
  input  logic                 start,
  output logic                 busy,
  output logic                 halted,
  output logic [AW-1:0]        pc,
  alu_sequencer_if.master      alu_if,
  output logic                 carry_flag,
  input  logic [1:0]           dbg_sel,
  output logic [DW-1:0]        dbg_data
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  instr_t        instr_q, instr_d;
  logic [2:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic          res_c_q, res_c_d;
  logic          carry_q, carry_d;
  logic          rf_we;
  logic [DW-1:0] ra_data, rb_data;

  logic [IW-1:0] prog_mem [PROG_DEPTH];

  // NOTE: program memory has no reset; its contents survive reset and only the host rewrites them.
  always_ff @(posedge clk) begin
    if (prog_we && !busy) prog_mem[prog_addr] <= prog_wdata;
  end

  seq_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (instr_q.rd),
    .wdata    (res_q),
    .ra_sel   (instr_q.ra),
    .rb_sel   (instr_q.rb),
    .dbg_sel  (dbg_sel),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    res_c_d = res_c_q;
    carry_d = carry_q;
    rf_we   = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        instr_d = instr_t'(prog_mem[pc_q]);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (instr_q.halt) begin
          state_d = S_HALTED;
        end else begin
          op_d    = instr_q.op;
          a_d     = ra_data;
          b_d     = instr_q.use_imm ? instr_q.imm : rb_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: if (alu_if.alu_ready) state_d = S_WAIT;
      S_WAIT: begin
        // The result is a one-cycle pulse, so hold it for the writeback cycle.
        if (alu_if.res_valid) begin
          res_d   = alu_if.alu_result;
          res_c_d = alu_if.alu_carry;
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        carry_d = res_c_q;
        pc_d    = pc_q + AW'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      res_c_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      res_c_q <= res_c_d;
      carry_q <= carry_d;
    end
  end

  always_ff @(posedge clk) instr_q <= instr_d;

  assign busy              = is_busy_state(state_q);
  assign halted            = (state_q == S_HALTED);
  assign pc                = pc_q;
  assign carry_flag        = carry_q;
  assign alu_if.alu_valid  = (state_q == S_ISSUE);
  assign alu_if.alu_opcode = op_q;
  assign alu_if.alu_a      = a_q;
  assign alu_if.alu_b      = b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: table of single-op programs, hand-written corner sequences and
// random programs checked against a behavioural execute-and-writeback model.
`timescale 1ns/1ps
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int LIMIT = 2000;

  typedef struct { int op; int a; int b; int exp_r; int exp_c; } vec_t;
  typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; } issue_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, prog_we = 1'b0, start = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [18:0] prog_wdata = '0;
  logic        busy, halted, carry_flag;
  logic [3:0]  pc;
  logic [1:0]  dbg_sel = '0;
  logic [7:0]  dbg_data;
  alu_sequencer_if bus ();

  alu_sequencer #(.PROG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .start(start), .busy(busy), .halted(halted), .pc(pc), .alu_if(bus.master),
    .carry_flag(carry_flag), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  logic        reset4 = 1'b1, prog_we4 = 1'b0, start4 = 1'b0;
  logic [1:0]  prog_addr4 = '0;
  logic [18:0] prog_wdata4 = '0;
  logic        busy4, halted4, carry_flag4;
  logic [1:0]  pc4;
  logic [7:0]  dbg_data4;
  alu_sequencer_if bus4 ();

  alu_sequencer #(.PROG_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset4), .prog_we(prog_we4), .prog_addr(prog_addr4), .prog_wdata(prog_wdata4),
    .start(start4), .busy(busy4), .halted(halted4), .pc(pc4), .alu_if(bus4.master),
    .carry_flag(carry_flag4), .dbg_sel(2'd1), .dbg_data(dbg_data4)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [18:0] ins(input int h, input int op, input int rd, input int ra,
                                      input int rb, input int ui, input int imm);
    return {h[0], op[2:0], rd[1:0], ra[1:0], rb[1:0], ui[0], imm[7:0]};
  endfunction

  // Reference execute unit: plain integer arithmetic per opcode.
  task automatic alu_ref(input int op, input int a, input int b, output logic [7:0] r, output logic c);
    int s;
    c = 1'b0;
    case (op)
      0: begin s = a + b; c = (s > 255); end
      1: begin s = a - b; c = (a < b); end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: begin s = a * b; c = (s > 255); end
      6: if (b == 0) begin s = 0; c = 1'b1; end else s = a / b;
      default: begin s = (a == b) ? 1 : 0; c = (a < b); end
    endcase
    r = 8'(s);
  endtask

  // Execute-unit model for the main DUT, driven on the falling edge.
  int ready_lat = 0, res_lat = 0, held = 0, res_cnt = 0, acc_cnt = 0;
  bit stray_ready = 0, inject_stray = 0, issue_chk = 0, acc_last = 0, pend = 0;
  logic [2:0] h_op;
  logic [7:0] h_a, h_b, p_r;
  logic p_c;
  issue_t exp_q[$];

  initial begin
    bus.alu_ready = 1'b0; bus.res_valid = 1'b0; bus.alu_result = '0; bus.alu_carry = 1'b0;
  end

  always @(negedge clk) begin
    bus.res_valid = 1'b0;
    if (reset) begin
      acc_last = 0; pend = 0; held = 0; bus.alu_ready = 1'b0;
    end else begin
      if (acc_last) begin
        acc_last = 0;
        alu_ref(int'(h_op), int'(h_a), int'(h_b), p_r, p_c);
        pend = 1; res_cnt = res_lat;
      end
      if (pend) begin
        if (res_cnt == 0) begin
          bus.res_valid = 1'b1; bus.alu_result = p_r; bus.alu_carry = p_c; pend = 0;
        end else res_cnt--;
      end else if (inject_stray) begin
        bus.res_valid = 1'b1; bus.alu_result = 8'h55; bus.alu_carry = 1'b0; inject_stray = 0;
      end
      if (bus.alu_valid) begin
        if (held > 0) check("issue_stable", {bus.alu_opcode, bus.alu_a, bus.alu_b}, {h_op, h_a, h_b});
        else begin h_op = bus.alu_opcode; h_a = bus.alu_a; h_b = bus.alu_b; end
        if (held >= ready_lat) begin
          bus.alu_ready = 1'b1; acc_last = 1; acc_cnt++; held = 0;
          if (issue_chk) begin
            if (exp_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL issue_extra: got op=%0d a=%0d b=%0d, required no further issue", h_op, h_a, h_b);
            end else begin
              check("issue_op_a_b", {h_op, h_a, h_b}, {exp_q[0].op, exp_q[0].a, exp_q[0].b});
              void'(exp_q.pop_front());
            end
          end
        end else begin
          bus.alu_ready = 1'b0; held++;
        end
      end else begin
        if (held > 0) begin
          n_tests++; n_fail++;
          $display("FAIL valid_dropped: alu_valid fell after %0d cycles without acceptance", held);
          held = 0;
        end
        bus.alu_ready = stray_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Minimal execute unit for the 4-deep instance: always ready, returns a+b one cycle later.
  logic acc4 = 1'b0;
  logic [7:0] sum4 = '0;
  initial begin
    bus4.alu_ready = 1'b1; bus4.res_valid = 1'b0; bus4.alu_result = '0; bus4.alu_carry = 1'b0;
  end
  always @(negedge clk) begin
    bus4.res_valid = 1'b0;
    if (acc4) begin bus4.res_valid = 1'b1; bus4.alu_result = sum4; end
    acc4 = bus4.alu_valid && !reset4;
    sum4 = bus4.alu_a + bus4.alu_b;
  end

  logic [18:0] prog_buf [16];

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = prog_buf[i];
    end
    @(negedge clk); prog_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_halt(output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (!halted && n < LIMIT) begin
      if (busy) busy_cycles++;
      @(negedge clk); n++;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic run(output int busy_cycles);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_halt(busy_cycles);
  endtask

  task automatic chk_reg(input string name, input int idx, input int exp);
    dbg_sel = 2'(idx);
    #1;
    check(name, dbg_data, 32'(exp));
  endtask

  vec_t tbl[13];

  initial begin
    int bc, n, acc0, last;
    int seq[$];
    bit poked;
    logic [7:0] m_regs [4];
    logic [7:0] mr;
    logic m_c, mc;

    tbl[0]  = '{0, 200, 100, 44, 1};
    tbl[1]  = '{0, 10, 20, 30, 0};
    tbl[2]  = '{1, 5, 7, 254, 1};
    tbl[3]  = '{1, 7, 5, 2, 0};
    tbl[4]  = '{2, 240, 60, 48, 0};
    tbl[5]  = '{3, 240, 60, 252, 0};
    tbl[6]  = '{4, 240, 60, 204, 0};
    tbl[7]  = '{5, 16, 16, 0, 1};
    tbl[8]  = '{5, 3, 5, 15, 0};
    tbl[9]  = '{6, 100, 7, 14, 0};
    tbl[10] = '{6, 9, 0, 0, 1};
    tbl[11] = '{7, 9, 9, 1, 0};
    tbl[12] = '{7, 3, 5, 0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    check("rst_valid", bus.alu_valid, 0);
    check("rst_op_a_b", {bus.alu_opcode, bus.alu_a, bus.alu_b}, 0);
    check("rst_carry", carry_flag, 0);
    for (int r = 0; r < 4; r++) chk_reg("rst_reg", r, 0);
    reset = 1'b0;

    // Basic program and minimum throughput
    prog_buf[0] = ins(0, 0, 1, 0, 0, 1, 5);
    prog_buf[1] = ins(0, 0, 2, 1, 0, 1, 7);
    prog_buf[2] = ins(1, 0, 0, 0, 0, 0, 0);
    load(3);
    run(bc);
    chk_reg("basic_r1", 1, 5);
    chk_reg("basic_r2", 2, 12);
    check("basic_pc", pc, 2);
    check("basic_busy", busy, 0);
    check("basic_busy_cycles", bc, 12);

    // Table of single-operation programs
    for (int i = 0; i < 13; i++) begin
      do_reset();
      prog_buf[0] = ins(0, 0, 1, 0, 0, 1, tbl[i].a);
      prog_buf[1] = ins(0, tbl[i].op, 2, 1, 0, 1, tbl[i].b);
      prog_buf[2] = ins(1, 0, 0, 0, 0, 0, 0);
      load(3);
      run(bc);
      chk_reg($sformatf("tbl%0d_result", i), 2, tbl[i].exp_r);
      check($sformatf("tbl%0d_carry", i), carry_flag, tbl[i].exp_c);
    end

    // Carry set by an overflowing add, then cleared by the next subtract
    do_reset();
    prog_buf[0] = ins(0, 0, 1, 0, 0, 1, 200);
    prog_buf[1] = ins(0, 0, 3, 1, 0, 1, 100);
    prog_buf[2] = ins(0, 1, 0, 0, 0, 0, 0);
    prog_buf[3] = ins(1, 0, 0, 0, 0, 0, 0);
    load(4);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (pc != 2 && n < LIMIT) begin @(negedge clk); n++; end
    check("carry_mid_pc", pc, 2);
    check("carry_mid_set", carry_flag, 1);
    chk_reg("carry_r3", 3, 44);
    wait_halt(bc);
    check("carry_cleared", carry_flag, 0);
    check("carry_end_pc", pc, 3);

    // Execute unit stalls for 6 cycles: one issue, operands held steady
    do_reset();
    ready_lat = 6;
    prog_buf[0] = ins(0, 0, 1, 0, 0, 1, 9);
    prog_buf[1] = ins(1, 0, 0, 0, 0, 0, 0);
    load(2);
    acc0 = acc_cnt;
    run(bc);
    ready_lat = 0;
    check("stall_issues", acc_cnt - acc0, 1);
    chk_reg("stall_r1", 1, 9);
    check("stall_busy_cycles", bc, 13);

    // Divide by zero, with a stray result pulse while fetching
    do_reset();
    prog_buf[0] = ins(0, 0, 1, 0, 0, 1, 9);
    prog_buf[1] = ins(0, 6, 2, 1, 0, 1, 0);
    prog_buf[2] = ins(1, 0, 0, 0, 0, 0, 0);
    load(3);
    acc0 = acc_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; inject_stray = 1;
    wait_halt(bc);
    chk_reg("div0_r1", 1, 9);
    chk_reg("div0_r2", 2, 0);
    check("div0_carry", carry_flag, 1);
    check("div0_issues", acc_cnt - acc0, 2);

    // Reset while waiting for a result, then restart from the retained program
    do_reset();
    res_lat = 5;
    prog_buf[0] = ins(0, 0, 1, 0, 0, 1, 9);
    prog_buf[1] = ins(0, 0, 2, 1, 0, 1, 1);
    prog_buf[2] = ins(1, 0, 0, 0, 0, 0, 0);
    load(3);
    acc0 = acc_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (acc_cnt < acc0 + 2 && n < LIMIT) begin @(negedge clk); n++; end
    check("wait_reached", acc_cnt - acc0, 2);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("rstw_valid", bus.alu_valid, 0);
    check("rstw_busy", busy, 0);
    check("rstw_pc", pc, 0);
    chk_reg("rstw_r1", 1, 0);
    chk_reg("rstw_r2", 2, 0);
    @(negedge clk); reset = 1'b0;
    res_lat = 0;
    run(bc);
    chk_reg("restart_r1", 1, 9);
    chk_reg("restart_r2", 2, 10);
    check("restart_pc", pc, 2);

    // Random programs against the reference model
    for (int it = 0; it < 25; it++) begin
      int np, op, rd, ra, rb, ui, imm, bv;
      do_reset();
      np = $urandom_range(1, 14);
      foreach (m_regs[k]) m_regs[k] = '0;
      m_c = 1'b0;
      exp_q.delete();
      for (int i = 0; i < np; i++) begin
        op = $urandom_range(0, 7); rd = $urandom_range(0, 3); ra = $urandom_range(0, 3);
        rb = $urandom_range(0, 3); ui = $urandom_range(0, 1); imm = $urandom_range(0, 255);
        prog_buf[i] = ins(0, op, rd, ra, rb, ui, imm);
        bv = ui ? imm : int'(m_regs[rb]);
        exp_q.push_back('{3'(op), m_regs[ra], 8'(bv)});
        alu_ref(op, int'(m_regs[ra]), bv, mr, mc);
        m_regs[rd] = mr;
        m_c = mc;
      end
      prog_buf[np] = ins(1, 0, 0, 0, 0, 0, 0);
      load(np + 1);
      ready_lat = $urandom_range(0, 3); res_lat = $urandom_range(0, 3);
      stray_ready = 1; issue_chk = 1;
      run(bc);
      stray_ready = 0; issue_chk = 0; ready_lat = 0; res_lat = 0;
      for (int r = 0; r < 4; r++) chk_reg($sformatf("rnd%0d_r%0d", it, r), r, int'(m_regs[r]));
      check($sformatf("rnd%0d_carry", it), carry_flag, m_c);
      check($sformatf("rnd%0d_pc", it), pc, np);
      check($sformatf("rnd%0d_pending", it), exp_q.size(), 0);
    end

    // 4-deep program without HALT wraps; start while busy is ignored
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); prog_we4 = 1'b1; prog_addr4 = 2'(i); prog_wdata4 = ins(0, 0, 1, 1, 0, 1, 1);
    end
    @(negedge clk); prog_we4 = 1'b0; reset4 = 1'b0;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    last = int'(pc4);
    seq.push_back(last);
    poked = 0; n = 0;
    while (seq.size() < 5 && n < LIMIT) begin
      @(negedge clk); n++;
      if (int'(pc4) != last) begin last = int'(pc4); seq.push_back(last); end
      if (!poked && seq.size() == 3) begin start4 = 1'b1; poked = 1; end
      else start4 = 1'b0;
    end
    start4 = 1'b0;
    check("wrap_seq_len", seq.size(), 5);
    foreach (seq[i]) check($sformatf("wrap_pc%0d", i), seq[i], i % 4);
    check("wrap_r1", dbg_data4, 4);
    check("wrap_busy", busy4, 1);
    reset4 = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
